// File: rtl/disp_pkg.sv
// Shared types and constants for the display scheduler.
package disp_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StShowHi,
        StShowLo
    } disp_state_e;

    // One second at 50 MHz.
    localparam int unsigned DefaultDwell = 50000000;

endpackage

// File: rtl/disp_rr_pick.sv
// Round-robin picker: first set bit of valid_i searching upward from start_i, with wrap.
module disp_rr_pick #(
    parameter int unsigned NSRC = 4,
    parameter int unsigned IW   = $clog2(NSRC)
) (
    input  logic [NSRC-1:0] valid_i,
    input  logic [IW-1:0]   start_i,
    output logic [IW-1:0]   pick_o,
    output logic            any_o
);

    int unsigned idx;

    always_comb begin
        pick_o = start_i;
        any_o  = |valid_i;
        idx    = 0;
        // Walk the ring backwards so the nearest candidate to start_i wins.
        for (int k = NSRC - 1; k >= 0; k--) begin
            idx = (32'(start_i) + 32'(k)) % NSRC;
            if (valid_i[idx]) begin
                pick_o = IW'(idx);
            end
        end
    end

endmodule

// File: rtl/disp_scheduler.sv
// Cycles registered source words onto LEDs, upper half then lower half, round-robin.
// Optional manual advance is enabled by defining DISP_STEP_EN.
module disp_scheduler
    import disp_pkg::*;
#(
    parameter int unsigned N     = 32,
    parameter int unsigned NSRC  = 4,
    parameter int unsigned DWELL = DefaultDwell
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NSRC*N-1:0]       src_data,
    input  logic [NSRC-1:0]         src_valid,
    input  logic                    hold,
    input  logic                    step,
    output logic [N/2-1:0]          led_out,
    output logic [$clog2(NSRC)-1:0] cur_src,
    output logic                    half,
    output logic                    frame_done
);

    localparam int unsigned IW = $clog2(NSRC);
    localparam int unsigned CW = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam int unsigned HW = N / 2;

    disp_state_e   state_q, state_d;
    logic [HW-1:0] led_q, led_d;
    logic [HW-1:0] snap_q, snap_d;
    logic [IW-1:0] cur_q, cur_d;
    logic          half_q, half_d;
    logic          fd_q, fd_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic [IW-1:0] start_idx;
    logic [IW-1:0] pick;
    logic          any_valid;
    logic [N-1:0]  sel_word;
    logic          step_adv;
    logic          adv;

`ifdef DISP_STEP_EN
    assign step_adv = step;
`else
    logic unused_step;
    assign unused_step = step;
    assign step_adv    = 1'b0;
`endif

    // IDLE resumes at cur_src itself; after a frame the current source is tried last.
    assign start_idx = (state_q == StIdle) ? cur_q :
                       (cur_q == IW'(NSRC - 1)) ? '0 : cur_q + IW'(1);

    disp_rr_pick #(
        .NSRC (NSRC),
        .IW   (IW)
    ) u_pick (
        .valid_i (src_valid),
        .start_i (start_idx),
        .pick_o  (pick),
        .any_o   (any_valid)
    );

    assign sel_word = src_data[int'(pick)*N +: N];
    assign adv      = (cnt_q == CW'(DWELL - 1)) || step_adv;

    always_comb begin
        state_d = state_q;
        led_d   = led_q;
        snap_d  = snap_q;
        cur_d   = cur_q;
        half_d  = half_q;
        fd_d    = 1'b0;
        cnt_d   = cnt_q;
        if (!hold) begin
            unique case (state_q)
                StIdle: begin
                    if (any_valid) begin
                        state_d = StShowHi;
                        cur_d   = pick;
                        led_d   = sel_word[N-1:HW];
                        snap_d  = sel_word[HW-1:0];
                        half_d  = 1'b0;
                        cnt_d   = '0;
                    end else begin
                        led_d  = '0;
                        half_d = 1'b0;
                    end
                end
                StShowHi: begin
                    if (adv) begin
                        state_d = StShowLo;
                        led_d   = snap_q;
                        half_d  = 1'b1;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                StShowLo: begin
                    if (adv) begin
                        fd_d   = 1'b1;
                        half_d = 1'b0;
                        cnt_d  = '0;
                        if (any_valid) begin
                            state_d = StShowHi;
                            cur_d   = pick;
                            led_d   = sel_word[N-1:HW];
                            snap_d  = sel_word[HW-1:0];
                        end else begin
                            state_d = StIdle;
                            led_d   = '0;
                        end
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            led_q   <= '0;
            snap_q  <= '0;
            cur_q   <= '0;
            half_q  <= 1'b0;
            fd_q    <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            led_q   <= led_d;
            snap_q  <= snap_d;
            cur_q   <= cur_d;
            half_q  <= half_d;
            fd_q    <= fd_d;
            cnt_q   <= cnt_d;
        end
    end

    assign led_out    = led_q;
    assign cur_src    = cur_q;
    assign half       = half_q;
    assign frame_done = fd_q;

endmodule

// File: tb/tb_disp_scheduler.sv
// Scoreboard bench for disp_scheduler (N=32, NSRC=4, DWELL=4).
module tb_disp_scheduler;

    typedef struct packed {
        logic [15:0] led;
        logic [1:0]  src;
        logic        half;
        logic        fd;
    } exp_t;

    logic         clk;
    logic         rst;
    logic [31:0]  src [4];
    logic [127:0] src_data;
    logic [3:0]   src_valid;
    logic         hold;
    logic         step;
    logic [15:0]  led_out;
    logic [1:0]   cur_src;
    logic         half;
    logic         frame_done;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    assign src_data = {src[3], src[2], src[1], src[0]};

    disp_scheduler #(
        .N     (32),
        .NSRC  (4),
        .DWELL (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .src_data   (src_data),
        .src_valid  (src_valid),
        .hold       (hold),
        .step       (step),
        .led_out    (led_out),
        .cur_src    (cur_src),
        .half       (half),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic push(input logic [1:0] s, input logic [15:0] led, input logic h,
                        input logic fd);
        exp_t e;
        e.led  = led;
        e.src  = s;
        e.half = h;
        e.fd   = fd;
        exp_q.push_back(e);
    endtask

    task automatic push_frame(input logic [1:0] s, input logic [15:0] hi, input logic [15:0] lo,
                              input logic fd_first);
        push(s, hi, 1'b0, fd_first);
        for (int i = 0; i < 3; i++) push(s, hi, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) push(s, lo, 1'b1, 1'b0);
    endtask

    task automatic run(input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            check_eq("sb_depth", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check_eq("led_out", 32'(led_out), 32'(e.led));
                check_eq("cur_src", 32'(cur_src), 32'(e.src));
                check_eq("half", 32'(half), 32'(e.half));
                check_eq("frame_done", 32'(frame_done), 32'(e.fd));
            end
        end
    endtask

    task automatic check_zero(input string tag);
        check_eq({tag, "_led"}, 32'(led_out), 32'd0);
        check_eq({tag, "_src"}, 32'(cur_src), 32'd0);
        check_eq({tag, "_half"}, 32'(half), 32'd0);
        check_eq({tag, "_fd"}, 32'(frame_done), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        hold      = 1'b0;
        step      = 1'b0;
        src_valid = 4'b0000;
        src[0]    = 32'hDEADBEEF;
        src[1]    = 32'h11112222;
        src[2]    = 32'hAAAABBBB;
        src[3]    = 32'h33334444;

        @(posedge clk);
        #1;
        check_zero("reset");

        // Single source, two back-to-back frames.
        src_valid = 4'b0001;
        rst       = 1'b0;
        push_frame(2'd0, 16'hDEAD, 16'hBEEF, 1'b0);
        push_frame(2'd0, 16'hDEAD, 16'hBEEF, 1'b1);
        run(16);

        // Alternating sources 1 and 3, including wrap from 3 back to 1.
        src_valid = 4'b1010;
        push_frame(2'd1, 16'h1111, 16'h2222, 1'b1);
        push_frame(2'd3, 16'h3333, 16'h4444, 1'b1);
        push_frame(2'd1, 16'h1111, 16'h2222, 1'b1);
        push_frame(2'd3, 16'h3333, 16'h4444, 1'b1);
        run(32);

        // Hold for 3 cycles in SHOW_HI stretches the upper half to 7 cycles.
        src_valid = 4'b0001;
        push(2'd0, 16'hDEAD, 1'b0, 1'b1);
        push(2'd0, 16'hDEAD, 1'b0, 1'b0);
        run(2);
        hold = 1'b1;
        for (int i = 0; i < 3; i++) push(2'd0, 16'hDEAD, 1'b0, 1'b0);
        run(3);
        hold = 1'b0;
        for (int i = 0; i < 2; i++) push(2'd0, 16'hDEAD, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) push(2'd0, 16'hBEEF, 1'b1, 1'b0);
        run(6);

        // Data change and valid drop mid-frame: frame completes from the snapshot, then IDLE.
        push(2'd0, 16'hDEAD, 1'b0, 1'b1);
        push(2'd0, 16'hDEAD, 1'b0, 1'b0);
        run(2);
        src[0]    = 32'h12345678;
        src_valid = 4'b0000;
        for (int i = 0; i < 2; i++) push(2'd0, 16'hDEAD, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) push(2'd0, 16'hBEEF, 1'b1, 1'b0);
        push(2'd0, 16'h0000, 1'b0, 1'b1);
        push(2'd0, 16'h0000, 1'b0, 1'b0);
        push(2'd0, 16'h0000, 1'b0, 1'b0);
        run(9);

        // From IDLE pick source 2, then reset asynchronously during SHOW_LO.
        src_valid = 4'b0100;
        for (int i = 0; i < 4; i++) push(2'd2, 16'hAAAA, 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) push(2'd2, 16'hBBBB, 1'b1, 1'b0);
        run(6);
        #2;
        check_eq("pre_rst_half", 32'(half), 32'd1);
        rst = 1'b1;
        #1;
        check_zero("async_rst");
        @(posedge clk);
        #1;
        check_zero("held_rst");
        src_valid = 4'b0101;
        rst       = 1'b0;
        push_frame(2'd0, 16'h1234, 16'h5678, 1'b0);
        run(8);

        // Step pulse at counter=1 in SHOW_HI.
        push(2'd2, 16'hAAAA, 1'b0, 1'b1);
        push(2'd2, 16'hAAAA, 1'b0, 1'b0);
        run(2);
        step = 1'b1;
`ifdef DISP_STEP_EN
        push(2'd2, 16'hBBBB, 1'b1, 1'b0);
        run(1);
        step = 1'b0;
        for (int i = 0; i < 3; i++) push(2'd2, 16'hBBBB, 1'b1, 1'b0);
        run(3);
`else
        push(2'd2, 16'hAAAA, 1'b0, 1'b0);
        run(1);
        step = 1'b0;
        push(2'd2, 16'hAAAA, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) push(2'd2, 16'hBBBB, 1'b1, 1'b0);
        run(5);
`endif
        push(2'd0, 16'h1234, 1'b0, 1'b1);
        run(1);

        check_eq("sb_left", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/disp_scheduler.md
DISP_SCHEDULER -- requirements
Module: disp_scheduler

Interface
REQ-001 SHALL have parameter N, default 32: width of each source register; even.
REQ-002 SHALL have parameter NSRC, default 4: number of display sources; range 2..8.
REQ-003 SHALL have parameter DWELL, default 50000000: clock cycles each half-word is shown; minimum 1.
REQ-004 SHALL have port clk  input  1: single clock; all state on rising edge.
REQ-005 SHALL have port rst  input  1: reset, asynchronous, active-high.
REQ-006 SHALL have port src_data  input  NSRC*N: source registers packed; source i at bits [i*N +: N].
REQ-007 SHALL have port src_valid  input  NSRC: bit i set means source i is eligible for display.
REQ-008 SHALL have port hold  input  1: level; freezes dwell timer and current display.
REQ-009 SHALL have port step  input  1: single-cycle pulse; manual advance; used only under DISP_STEP_EN.
REQ-010 SHALL have port led_out  output  N/2: registered half-word shown on LEDs.
REQ-011 SHALL have port cur_src  output  clog2(NSRC): registered index of source being shown.
REQ-012 SHALL have port half  output  1: registered; 0 = upper half shown, 1 = lower half shown.
REQ-013 SHALL have port frame_done  output  1: registered one-cycle pulse when a source's lower half finishes.

Function
REQ-014 SHALL implement FSM states IDLE, SHOW_HI, SHOW_LO.
REQ-015 IDLE: when any src_valid bit is set, SHALL select the first valid index searching from cur_src inclusive upward, with wrap.
- Same edge: load cur_src, set led_out to the selected source's upper half, snapshot its lower half, half=0, dwell counter=0, enter SHOW_HI.
REQ-016 IDLE with src_valid all zero SHALL hold led_out=0 and half=0.
REQ-017 In SHOW_HI and SHOW_LO the dwell counter SHALL increment once per cycle while hold=0; counter width clog2(DWELL), minimum 1 bit.
REQ-018 SHOW_HI SHALL exit when the counter equals DWELL-1 and hold=0.
- Exit actions: led_out = snapshot, half=1, counter=0, enter SHOW_LO.
- Result: each half is visible exactly DWELL cycles with no hold.
REQ-019 SHOW_LO exit on the same condition SHALL pulse frame_done for one cycle, then:
- if any valid: select the next source searching cur_src+1 upward with wrap (cur_src itself last) and enter SHOW_HI as in REQ-015;
- else: enter IDLE with led_out=0.
REQ-020 The lower half SHALL come from the snapshot taken at SHOW_HI entry; src_data changes mid-frame SHALL NOT affect the frame.
REQ-021 src_valid deassertion mid-frame SHALL NOT abort the frame; it affects only the next selection.
REQ-022 hold=1 SHALL freeze the counter, state and all outputs; hold takes priority over step.
REQ-023 DWELL=1 SHALL give one cycle per half, back to back, with no idle gap between sources.

Reset
REQ-024 rst SHALL immediately, in any state, force: state=IDLE, led_out=0, cur_src=0, half=0, frame_done=0, counter=0, snapshot=0.
REQ-025 The first cycle after rst release SHALL obey REQ-015/016.

Configuration
REQ-026 Macro DISP_STEP_EN defined: step=1 with hold=0 in SHOW_HI or SHOW_LO SHALL act as if the counter reached DWELL-1 that cycle; step in IDLE SHALL be ignored.
REQ-027 Macro DISP_STEP_EN undefined: step SHALL be ignored entirely; the port remains present.

Structure
REQ-028 Shared package disp_pkg SHALL hold the FSM state enum typedef and the default DWELL constant.
REQ-029 Round-robin selection SHALL be a combinational sub-module disp_rr_pick.
- Inputs: valid vector, start index.
- Outputs: chosen index, any-valid flag.

Verification (N=32, NSRC=4, DWELL=4 unless noted)
REQ-030 src_valid=0001, src0=0xDEADBEEF: led_out=0xDEAD for 4 cycles, then 0xBEEF for 4 cycles; frame_done pulses on the SHOW_LO exit edge; the sequence repeats.
REQ-031 src_valid=1010: cur_src sequence 1,3,1,3; each frame 8 cycles.
REQ-032 hold=1 for 3 cycles during SHOW_HI: upper half visible 7 cycles; lower half visible 4.
REQ-033 src0 changed to 0x12345678 during SHOW_HI, then src_valid=0000: lower half still shows 0xBEEF; then IDLE with led_out=0x0000.
REQ-034 rst pulsed during SHOW_LO: all outputs 0 without waiting for a clock edge; after release, restarts at source 0.
REQ-035 DISP_STEP_EN defined, step pulse at counter=1 in SHOW_HI: lower half appears on the next edge. DISP_STEP_EN undefined: no effect.
